// File: rtl/serial_subtractor_8bit.sv
// serial_subtractor_8bit
//   Bit-serial subtractor computing a - b one bit per clock, LSB first,
//   using a single full-subtractor cell, two operand shift registers, a
//   result shift register and a two-state controller.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       synchronous, active-high reset
//   i_start     operation request, accepted only while o_busy is low
//   i_a         minuend, captured on the accepting edge
//   i_b         subtrahend, captured on the accepting edge
//   o_diff      a - b mod 2^WIDTH, holds the last completed result
//   o_borrow    1 when unsigned a < b, holds the last completed result
//   o_overflow  two's-complement overflow of a - b, holds the last result
//   o_busy      high while an operation is in progress
//   o_done      one-cycle pulse when o_diff/o_borrow/o_overflow are new
module serial_subtractor_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Controller state
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_finish;

  // Datapath registers
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CNT_W-1:0] r_cnt;

  // Output registers
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  // Full-subtractor cell and completion terms
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d_bit;
  logic             w_bout;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_nxt;

  // Single full-subtractor cell working on the operand LSBs
  always_comb begin
    w_a_bit   = r_a_sh[0];
    w_b_bit   = r_b_sh[0];
    w_d_bit   = w_a_bit ^ w_b_bit ^ r_bin;
    w_bout    = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_bin);
    w_res_nxt = {w_d_bit, r_res[WIDTH-1:1]};
    w_last    = (r_cnt == LAST_BIT);
    // On the last bit the operand LSBs are the original sign bits, so the
    // overflow test needs no separately stored copy of a and b.
    w_ovf     = (w_a_bit != w_b_bit) && (w_d_bit != w_a_bit);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, bit shifting, borrow chain and bit counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_res  <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= i_a;
      r_b_sh <= i_b;
      r_res  <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_res  <= w_res_nxt;
      r_bin  <= w_bout;
      r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Result registers change only on completion; busy/done track the FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= w_finish;
      if (w_finish) begin
        r_diff     <= w_res_nxt;
        r_borrow   <= w_bout;
        r_overflow <= w_ovf;
      end
    end
  end

  assign o_diff     = r_diff;
  assign o_borrow   = r_borrow;
  assign o_overflow = r_overflow;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Testbench for serial_subtractor_8bit: directed and randomized operations,
// expected results queued by the driver and checked by a done monitor.
module tb_serial_subtractor_8bit;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
    int               t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .o_diff     (diff),
    .o_borrow   (borrow),
    .o_overflow (overflow),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input int t);
    exp_t e;
    int   ua, ub, sa, sb, sd;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sd = sa - sb;
    e.d  = WIDTH'((ua - ub + 256) % 256);
    e.br = (ua < ub);
    e.ov = (sd > 127) || (sd < -128);
    e.t  = t;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow", 32'(borrow), 32'(e.br));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("done_cycle", 32'(cyc), 32'(e.t));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_not_busy: got busy=%b, required 0 within 50 cycles", busy);
    end
  endtask

  // Issue one operation and queue its expected result; a/b are scrambled after capture
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
    wait_not_busy();
    a     = ia;
    b     = ib;
    start = 1'b1;
    q.push_back(model(ia, ib, cyc + 1 + int'(WIDTH)));
    @(negedge clk);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
    end
  endtask

  int t0;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({diff, borrow, overflow, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run with busy-window check
    issue(8'h5A, 8'h23);
    for (int i = 0; i < int'(WIDTH); i++) begin
      check("busy_run", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("done_after_8", 32'(done), 32'd1);
    wait_drain();

    // Borrow, edge values and signed overflow
    issue(8'h10, 8'h20);
    issue(8'h00, 8'h00);
    issue(8'hFF, 8'hFF);
    issue(8'h00, 8'hFF);
    issue(8'h80, 8'h01);
    issue(8'h7F, 8'hFF);
    wait_drain();

    // Handshake: start while busy ignored, start held through done accepted
    wait_not_busy();
    t0 = cyc;
    issue(8'h05, 8'h03);
    while (cyc < t0 + 3) @(negedge clk);
    start = 1'b1;
    a     = 8'h99;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hC3;
    b     = 8'h3C;
    while (cyc < t0 + 8) @(negedge clk);
    start = 1'b1;
    a     = 8'h09;
    b     = 8'h04;
    q.push_back(model(8'h09, 8'h04, t0 + 10 + int'(WIDTH)));
    @(negedge clk);
    check("hs_busy_low_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hs_second_busy", 32'(busy), 32'd1);
    wait_drain();

    // Reset mid-operation
    issue(8'h5A, 8'h23);
    wait_drain();
    check("prior_diff", 32'(diff), 32'h37);
    t0    = cyc;
    a     = 8'hF0;
    b     = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset", 32'({diff, borrow, overflow, busy, done}), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("aborted_stays_idle", 32'(busy), 32'd0);
    issue(8'h33, 8'h11);
    wait_drain();

    // Randomized operations, including back-to-back starts in the done cycle
    for (int i = 0; i < 40; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
